// File: rtl/usb_in_txn_ctrl.sv
// Host-side USB IN-transaction sequencer: IN token, receive, classify, ACK handshake, retry, completion report.
// Build option: define USB_IN_RETRY_EN to include the error-retry path (otherwise any receive error ends with ERROR).
module usb_in_txn_ctrl #(
    parameter int MAX_RETRIES = 3,
    parameter int WDOG_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transStart,
    input  logic       expDataSeq,
    output logic       sendTokenEn,
    input  logic       sendTokenRdy,
    output logic       getPacketEn,
    input  logic       RXPacketRdy,
    input  logic [7:0] RXPktStatus,
    input  logic [3:0] RxPID,
    output logic       sendAckEn,
    input  logic       sendAckRdy,
    output logic       busy,
    output logic       transDone,
    output logic [7:0] transStatus,
    output logic [2:0] result,
    output logic       nextDataSeq,
    output logic [3:0] retryCnt
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TOKEN   = 3'd1,
        S_ARM     = 3'd2,
        S_WAIT_RX = 3'd3,
        S_EVAL    = 3'd4,
        S_ACK     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [2:0]  RES_OK       = 3'd0;
    localparam logic [2:0]  RES_NAK      = 3'd1;
    localparam logic [2:0]  RES_STALL    = 3'd2;
    localparam logic [2:0]  RES_SEQ      = 3'd3;
    localparam logic [2:0]  RES_ERROR    = 3'd4;
    localparam logic [2:0]  RES_WATCHDOG = 3'd5;
    localparam logic [3:0]  PID_DATA0    = 4'h3;
    localparam logic [3:0]  PID_DATA1    = 4'hB;
    localparam logic [3:0]  PID_NAK      = 4'hA;
    localparam logic [3:0]  PID_STALL    = 4'hE;
    localparam logic [15:0] WDOG_LIM     = 16'(WDOG_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] wdog_q, wdog_d, wdog_inc_s;
    logic        exp_seq_q, exp_seq_d;
    logic [7:0]  rx_status_q, rx_status_d;
    logic [3:0]  rx_pid_q, rx_pid_d;
    logic        send_token_en_q, send_token_en_d;
    logic        get_packet_en_q, get_packet_en_d;
    logic        send_ack_en_q, send_ack_en_d;
    logic        busy_q, busy_d;
    logic        trans_done_q, trans_done_d;
    logic [7:0]  trans_status_q, trans_status_d;
    logic [2:0]  result_q, result_d;
    logic        next_seq_q, next_seq_d;
    logic        pid_data_s, pid_hs_s, rx_err_s;
`ifdef USB_IN_RETRY_EN
    localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);
    logic [3:0]  retry_cnt_q, retry_cnt_d;
`endif

    // Next-state, watchdog, latches and result; registered outputs decode the next state.
    always_comb begin
        state_d        = state_q;
        wdog_d         = wdog_q;
        exp_seq_d      = exp_seq_q;
        rx_status_d    = rx_status_q;
        rx_pid_d       = rx_pid_q;
        trans_status_d = trans_status_q;
        result_d       = result_q;
        next_seq_d     = next_seq_q;
`ifdef USB_IN_RETRY_EN
        retry_cnt_d    = retry_cnt_q;
`endif
        wdog_inc_s = (wdog_q == 16'hFFFF) ? wdog_q : (wdog_q + 16'd1);
        pid_data_s = (rx_pid_q == PID_DATA0) || (rx_pid_q == PID_DATA1);
        pid_hs_s   = (rx_pid_q == PID_NAK) || (rx_pid_q == PID_STALL);
        // A handshake PID with neither handshake bit set is as unusable as a bad PID.
        rx_err_s   = rx_status_q[3] | rx_status_q[1] | rx_status_q[0]
                   | ~(pid_data_s | pid_hs_s)
                   | (pid_hs_s & ~rx_status_q[5] & ~rx_status_q[4]);

        case (state_q)
            S_IDLE: begin
                if (transStart) begin
                    state_d   = S_TOKEN;
                    exp_seq_d = expDataSeq;
                    wdog_d    = 16'd0;
`ifdef USB_IN_RETRY_EN
                    retry_cnt_d = 4'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TOKEN: begin
                if (sendTokenRdy) begin
                    state_d = S_ARM;
                end else begin
                    state_d = S_TOKEN;
                end
            end
            S_ARM: begin
                wdog_d      = 16'd0;
                rx_status_d = 8'd0;
                rx_pid_d    = 4'd0;
                state_d     = S_WAIT_RX;
            end
            S_WAIT_RX: begin
                wdog_d = wdog_inc_s;
                if (RXPacketRdy) begin
                    rx_status_d = RXPktStatus;
                    rx_pid_d    = RxPID;
                    state_d     = S_EVAL;
                end else if (wdog_inc_s == WDOG_LIM) begin
                    result_d       = RES_WATCHDOG;
                    trans_status_d = {1'b1, rx_status_q[6:0]};
                    next_seq_d     = exp_seq_q;
                    state_d        = S_DONE;
                end else begin
                    state_d = S_WAIT_RX;
                end
            end
            S_EVAL: begin
                trans_status_d = rx_status_q;
                next_seq_d     = exp_seq_q;
                if (rx_err_s) begin
`ifdef USB_IN_RETRY_EN
                    if (retry_cnt_q < MAX_R) begin
                        retry_cnt_d    = retry_cnt_q + 4'd1;
                        trans_status_d = trans_status_q;
                        next_seq_d     = next_seq_q;
                        state_d        = S_TOKEN;
                    end else begin
                        result_d = RES_ERROR;
                        state_d  = S_DONE;
                    end
`else
                    result_d = RES_ERROR;
                    state_d  = S_DONE;
`endif
                end else if (rx_status_q[5]) begin
                    result_d = RES_STALL;
                    state_d  = S_DONE;
                end else if (rx_status_q[4]) begin
                    result_d = RES_NAK;
                    state_d  = S_DONE;
                end else if (rx_status_q[7] == exp_seq_q) begin
                    result_d   = RES_OK;
                    next_seq_d = ~exp_seq_q;
                    state_d    = S_ACK;
                end else begin
                    result_d = RES_SEQ;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (sendAckRdy) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        send_token_en_d = (state_d == S_TOKEN);
        get_packet_en_d = (state_d == S_ARM);
        send_ack_en_d   = (state_d == S_ACK);
        trans_done_d    = (state_d == S_DONE);
        busy_d          = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            wdog_q          <= 16'd0;
            exp_seq_q       <= 1'b0;
            rx_status_q     <= 8'd0;
            rx_pid_q        <= 4'd0;
            send_token_en_q <= 1'b0;
            get_packet_en_q <= 1'b0;
            send_ack_en_q   <= 1'b0;
            busy_q          <= 1'b0;
            trans_done_q    <= 1'b0;
            trans_status_q  <= 8'd0;
            result_q        <= 3'd0;
            next_seq_q      <= 1'b0;
`ifdef USB_IN_RETRY_EN
            retry_cnt_q     <= 4'd0;
`endif
        end else begin
            state_q         <= state_d;
            wdog_q          <= wdog_d;
            exp_seq_q       <= exp_seq_d;
            rx_status_q     <= rx_status_d;
            rx_pid_q        <= rx_pid_d;
            send_token_en_q <= send_token_en_d;
            get_packet_en_q <= get_packet_en_d;
            send_ack_en_q   <= send_ack_en_d;
            busy_q          <= busy_d;
            trans_done_q    <= trans_done_d;
            trans_status_q  <= trans_status_d;
            result_q        <= result_d;
            next_seq_q      <= next_seq_d;
`ifdef USB_IN_RETRY_EN
            retry_cnt_q     <= retry_cnt_d;
`endif
        end
    end

    assign sendTokenEn = send_token_en_q;
    assign getPacketEn = get_packet_en_q;
    assign sendAckEn   = send_ack_en_q;
    assign busy        = busy_q;
    assign transDone   = trans_done_q;
    assign transStatus = trans_status_q;
    assign result      = result_q;
    assign nextDataSeq = next_seq_q;
`ifdef USB_IN_RETRY_EN
    assign retryCnt    = retry_cnt_q;
`else
    assign retryCnt    = 4'd0;
`endif

endmodule

// File: tb/tb_usb_in_txn_ctrl.sv
// Randomized bench for usb_in_txn_ctrl: plays token/receive/ACK partners and checks against a transaction-level model.
module tb_usb_in_txn_ctrl;
    localparam int MAXR = 3;
    localparam int WDOG = 20;
`ifdef USB_IN_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, transStart, expDataSeq, sendTokenRdy, RXPacketRdy, sendAckRdy;
    logic [7:0] RXPktStatus;
    logic [3:0] RxPID;
    logic       sendTokenEn, getPacketEn, sendAckEn, busy, transDone, nextDataSeq;
    logic [7:0] transStatus;
    logic [2:0] result;
    logic [3:0] retryCnt;
    logic [20:0] outs_s;

    int cyc = 0;
    int done_seen = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    usb_in_txn_ctrl #(.MAX_RETRIES(MAXR), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .transStart(transStart), .expDataSeq(expDataSeq),
        .sendTokenEn(sendTokenEn), .sendTokenRdy(sendTokenRdy), .getPacketEn(getPacketEn),
        .RXPacketRdy(RXPacketRdy), .RXPktStatus(RXPktStatus), .RxPID(RxPID),
        .sendAckEn(sendAckEn), .sendAckRdy(sendAckRdy), .busy(busy), .transDone(transDone),
        .transStatus(transStatus), .result(result), .nextDataSeq(nextDataSeq), .retryCnt(retryCnt)
    );

    assign outs_s = {sendTokenEn, getPacketEn, sendAckEn, busy, transDone,
                     transStatus, result, nextDataSeq, retryCnt};

    // Cycle index and count of transDone pulses.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        done_seen <= done_seen + (transDone ? 1 : 0);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference classification: 0 OK, 1 NAK, 2 STALL, 3 SEQ_MISMATCH, 4 error (retry candidate).
    function automatic int classify(input logic [7:0] st, input logic [3:0] pid, input logic es);
        bit is_data, is_hs;
        is_data = (pid == 4'h3) || (pid == 4'hB);
        is_hs   = (pid == 4'hA) || (pid == 4'hE);
        if (st[3] || st[1] || st[0] || !(is_data || is_hs)) return 4;
        if (st[5]) return 2;
        if (st[4]) return 1;
        if (!is_data) return 4;
        return (st[7] == es) ? 0 : 3;
    endfunction

    task automatic gen_resp(input int kind, output logic [7:0] st, output logic [3:0] pid);
        logic [7:0] r, eb;
        r = 8'($urandom);
        case (r[4:3])
            2'd0:    eb = 8'h08;
            2'd1:    eb = 8'h02;
            default: eb = 8'h01;
        endcase
        case (kind)
            0:  begin pid = r[0] ? 4'hB : 4'h3; st = {r[1], 1'b1, 3'b000, r[2], 2'b00}; end
            1:  begin pid = 4'hA; st = {4'b0001, 1'b0, r[2], 2'b00}; end
            2:  begin pid = 4'hE; st = {4'b0010, 1'b0, r[2], 2'b00}; end
            3:  begin pid = r[0] ? 4'hB : 4'h3; st = 8'($urandom) | eb; end
            10: begin pid = 4'hB; st = 8'hC0; end
            11: begin pid = 4'hA; st = 8'h10; end
            12: begin pid = 4'hB; st = 8'h80; end
            13: begin pid = 4'h3; st = 8'h01; end
            default: begin
                pid = 4'($urandom);
                st  = 8'($urandom);
                if ((pid == 4'hA || pid == 4'hE) && st[5:4] == 2'b00) st[4] = 1'b1;
            end
        endcase
    endtask

    // One IN transaction; fkind/fseq < 0 selects random response kind / expected toggle.
    task automatic run_txn(input int fkind, input int fseq);
        logic es, e_next;
        logic [7:0] st, e_st;
        logic [3:0] pid;
        logic [2:0] e_res;
        int kind, cls, tokens, retries, a_cyc, wait_n, dly, base_done;
        bit fin, wd;
        es = (fseq < 0) ? 1'($urandom) : 1'(fseq);
        base_done = done_seen;
        tokens = 0; retries = 0; fin = 1'b0; wd = 1'b0;
        e_res = 3'd0; e_st = 8'd0; e_next = 1'b0;
        transStart = 1'b1; expDataSeq = es;
        tick();
        transStart = 1'b0; expDataSeq = 1'($urandom);
        chk_eq("busy_start", 32'(busy), 32'd1);
        while (!fin) begin
            chk_eq("token_req", 32'(sendTokenEn), 32'd1);
            tokens++;
            dly = $urandom_range(0, 2);
            repeat (dly) begin tick(); chk_eq("token_hold", 32'(sendTokenEn), 32'd1); end
            sendTokenRdy = 1'b1;
            tick();
            sendTokenRdy = 1'b0;
            chk_eq("arm_pulse", 32'(getPacketEn), 32'd1);
            chk_eq("token_drop", 32'(sendTokenEn), 32'd0);
            a_cyc = cyc;
            kind = (fkind >= 0) ? fkind : (($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 4));
            // A receive pulse during the arm cycle is outside WAIT_RX and must be ignored.
            RXPacketRdy = ($urandom_range(0, 3) == 0);
            RXPktStatus = 8'($urandom); RxPID = 4'($urandom);
            tick();
            RXPacketRdy = 1'b0;
            chk_eq("arm_one_cycle", 32'(getPacketEn), 32'd0);
            if (kind == 5) begin
                for (int i = 0; i < WDOG + 4 && !transDone; i++) begin
                    transStart = ($urandom_range(0, 5) == 0);
                    tick();
                end
                transStart = 1'b0;
                // Expiry after WDOG receive-wait cycles; DONE follows the arm cycle by WDOG+1.
                chk_eq("wdog_latency", 32'(cyc - a_cyc), 32'(WDOG + 1));
                chk_eq("wdog_status7", 32'(transStatus[7]), 32'd1);
                e_res = 3'd5; e_next = es; wd = 1'b1; fin = 1'b1;
            end else begin
                wait_n = $urandom_range(1, WDOG);
                repeat (wait_n - 1) begin
                    transStart = ($urandom_range(0, 5) == 0);
                    expDataSeq = 1'($urandom);
                    tick();
                end
                transStart = 1'b0;
                gen_resp(kind, st, pid);
                RXPacketRdy = 1'b1; RXPktStatus = st; RxPID = pid;
                tick();
                RXPacketRdy = 1'b0; RXPktStatus = 8'($urandom); RxPID = 4'($urandom);
                chk_eq("eval_no_done", 32'(transDone), 32'd0);
                tick();
                cls = classify(st, pid, es);
                if (cls == 4 && RETRY_EN && retries < MAXR) begin
                    retries++;
                end else begin
                    e_res = 3'(cls); e_st = st; fin = 1'b1;
                    e_next = (cls == 0) ? ~es : es;
                    if (cls == 0 || cls == 3) begin
                        chk_eq("ack_req", 32'(sendAckEn), 32'd1);
                        chk_eq("no_done_before_ack", 32'(transDone), 32'd0);
                        dly = $urandom_range(0, 2);
                        repeat (dly) begin tick(); chk_eq("ack_hold", 32'(sendAckEn), 32'd1); end
                        sendAckRdy = 1'b1;
                        tick();
                        sendAckRdy = 1'b0;
                        chk_eq("ack_drop", 32'(sendAckEn), 32'd0);
                    end else begin
                        chk_eq("no_ack", 32'(sendAckEn), 32'd0);
                    end
                end
            end
        end
        chk_eq("done_pulse", 32'(transDone), 32'd1);
        chk_eq("result", 32'(result), 32'(e_res));
        if (!wd) chk_eq("status", 32'(transStatus), 32'(e_st));
        chk_eq("next_seq", 32'(nextDataSeq), 32'(e_next));
        chk_eq("retry_cnt", 32'(retryCnt), 32'(retries));
        chk_eq("tokens", 32'(tokens), 32'(retries + 1));
        tick();
        chk_eq("done_one_cycle", 32'(transDone), 32'd0);
        chk_eq("idle_after_done", 32'(busy), 32'd0);
        chk_eq("result_hold", 32'(result), 32'(e_res));
        tick();
        chk_eq("done_count", 32'(done_seen - base_done), 32'd1);
    endtask

    task automatic reset_mid_txn();
        int base;
        base = done_seen;
        transStart = 1'b1; expDataSeq = 1'b1;
        tick();
        transStart = 1'b0;
        sendTokenRdy = 1'b1;
        tick();
        sendTokenRdy = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_eq("rst_mid_outputs", 32'(outs_s), 32'd0);
        tick();
        chk_eq("rst_mid_hold", 32'(outs_s), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk_eq("rst_after_outputs", 32'(outs_s), 32'd0);
        chk_eq("rst_no_done", 32'(done_seen - base), 32'd0);
    endtask

    initial begin
        rst = 1'b1; transStart = 1'b0; expDataSeq = 1'b0; sendTokenRdy = 1'b0;
        RXPacketRdy = 1'b0; RXPktStatus = 8'd0; RxPID = 4'd0; sendAckRdy = 1'b0;
        repeat (3) tick();
        chk_eq("reset_outputs", 32'(outs_s), 32'd0);
        rst = 1'b0;
        tick();
        // Stray receive pulse while idle.
        RXPacketRdy = 1'b1; RXPktStatus = 8'hC0; RxPID = 4'hB;
        tick();
        RXPacketRdy = 1'b0;
        tick();
        chk_eq("stray_rx_idle", 32'(outs_s), 32'd0);

        run_txn(10, 1);
        run_txn(11, 0);
        run_txn(12, 0);
        run_txn(13, -1);
        run_txn(5, -1);
        reset_mid_txn();
        run_txn(10, 1);
        for (int n = 0; n < 40; n++) run_txn(-1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
